wb_port_arbiter: RTL and testbench

//   Shares the register file's single write port between the in-order pipeline writeback

---
 rtl/wb_arb_pkg.sv | 9 +
 rtl/wb_fifo.sv | 36 +++
 rtl/wb_port_arbiter.sv | 67 ++++++
 tb/tb_wb_port_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths and the write-request record used by the writeback port arbiter
package wb_arb_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  typedef struct packed {
    logic [RA_W-1:0] wa;
    logic [XLEN-1:0] wd;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t (clk, reset active-low sync, push/din, pop/dout, full, empty)
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  wb_req_t mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between WB and buffered MDU results, tracks MDU-pending regs (starve guard: WB_ARB_STARVE_GUARD_EN)
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_wr_en,
  input  logic [RA_W-1:0] p_wa,
  input  logic [XLEN-1:0] p_wd,
  input  logic            m_valid,
  input  logic [RA_W-1:0] m_wa,
  input  logic [XLEN-1:0] m_wd,
  output logic            m_ready,
  input  logic            iss_valid,
  input  logic [RA_W-1:0] iss_rd,
  output logic            rf_wr,
  output logic [RA_W-1:0] rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     pend_mask,
  output logic            stall_pipe
);
  wb_req_t head;
  logic full, empty, push, pop, p_win;
  logic [31:0] pend_q, set_m, clr_m;
  assign m_ready = reset && !full;
  assign push = m_valid && m_ready;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  ('{wa: m_wa, wd: m_wd}),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );
`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve;
  assign stall_pipe = reset && !empty && starve == LIM;
  always_ff @(posedge clk)
    starve <= (!reset || empty || pop) ? '0 : starve + 1'b1;
`else
  assign stall_pipe = 1'b0;
`endif
  assign p_win = reset && p_wr_en && !stall_pipe;
  assign pop = reset && !p_win && !empty;
  assign rf_wr = p_win ? |p_wa : pop && |head.wa;
  assign rf_wa = p_win ? p_wa : head.wa;
  assign rf_wd = p_win ? p_wd : head.wd;
  assign set_m = iss_valid ? 32'(1) << iss_rd : '0;
  assign clr_m = pop ? 32'(1) << head.wa : '0;
  assign pend_mask = pend_q;
  always_ff @(posedge clk)
    pend_q <= !reset ? '0 : ((pend_q & ~clr_m) | set_m) & ~32'd1;
  a_cfg: assert property (@(posedge clk) DEPTH >= 2 && STARVE_LIMIT >= 1);
  a_iss: assert property (@(posedge clk) disable iff (!reset)
    iss_valid && iss_rd != '0 |-> !pend_q[iss_rd] || clr_m[iss_rd]);
  a_waw: assert property (@(posedge clk) disable iff (!reset)
    p_wr_en && p_wa != '0 |-> !pend_q[p_wa]);
  a_hold: assert property (@(posedge clk) disable iff (!reset)
    stall_pipe |=> $stable(p_wr_en));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_wr_en = 1'b0;
  logic [4:0]  p_wa = '0;
  logic [31:0] p_wd = '0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic        m_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        rf_wr;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;
  logic        stall_pipe;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_wr_en   (p_wr_en),
    .p_wa      (p_wa),
    .p_wd      (p_wd),
    .m_valid   (m_valid),
    .m_wa      (m_wa),
    .m_wd      (m_wd),
    .m_ready   (m_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_wr     (rf_wr),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pend_mask (pend_mask),
    .stall_pipe(stall_pipe)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic r, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic iv, input logic [4:0] ir);
    @(posedge clk);
    #1;
    reset = r;
    p_wr_en = pw;
    p_wa = pa;
    p_wd = pd;
    m_valid = mv;
    m_wa = ma;
    m_wd = md;
    iss_valid = iv;
    iss_rd = ir;
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 1, 5, 32'h1, 0, 0);
    drv(0, 0, 0, 0, 1, 5, 32'h1, 0, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_stall", stall_pipe, 0);
    chk("rst_pend", pend_mask, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rel_m_ready", m_ready, 1);
    chk("rel_rf_wr", rf_wr, 0);
    chk("rel_pend", pend_mask, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("t2_iss_rf_wr", rf_wr, 0);
    drv(1, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
    chk("t2_pend_set", pend_mask, 32'h20);
    chk("t2_no_bypass", rf_wr, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rf_wr", rf_wr, 1);
    chk("t2_rf_wa", rf_wa, 5);
    chk("t2_rf_wd", rf_wd, 32'hDEAD_BEEF);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_pend_clr", pend_mask, 0);
    chk("t2_idle_wr", rf_wr, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 7);
    drv(1, 0, 0, 0, 1, 7, 32'h22, 0, 0);
    drv(1, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    chk("t3_p_wr", rf_wr, 1);
    chk("t3_p_wa", rf_wa, 3);
    chk("t3_p_wd", rf_wd, 32'h11);
    chk("t3_pend7", pend_mask, 32'h80);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_m_wr", rf_wr, 1);
    chk("t3_m_wa", rf_wa, 7);
    chk("t3_m_wd", rf_wd, 32'h22);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 7);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 8);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 9);
    drv(1, 1, 1, 32'hA1, 1, 7, 32'h77, 0, 0);
    chk("t4_c1_m_ready", m_ready, 1);
    chk("t4_c1_rf_wa", rf_wa, 1);
    chk("t4_pend", pend_mask, 32'h380);
    drv(1, 1, 1, 32'hA1, 1, 8, 32'h88, 0, 0);
    chk("t4_c2_m_ready", m_ready, 1);
    chk("t4_c2_rf_wa", rf_wa, 1);
    drv(1, 1, 1, 32'hA1, 1, 9, 32'h99, 0, 0);
    chk("t4_c3_full", m_ready, 0);
    drv(1, 1, 1, 32'hA1, 1, 9, 32'h99, 0, 0);
    chk("t4_c4_full", m_ready, 0);
    drv(1, 1, 1, 32'hA1, 1, 9, 32'h99, 0, 0);
    chk("t4_c5_stall", stall_pipe, 0);
    drv(1, 1, 1, 32'hA1, 1, 9, 32'h99, 0, 0);
`ifdef WB_ARB_STARVE_GUARD_EN
    chk("t4_c6_stall", stall_pipe, 1);
    chk("t4_c6_rf_wa", rf_wa, 7);
    chk("t4_c6_rf_wd", rf_wd, 32'h77);
    drv(1, 1, 1, 32'hA1, 1, 9, 32'h99, 0, 0);
    chk("t4_c7_rf_wa", rf_wa, 1);
    chk("t4_c7_m_ready", m_ready, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_c8_rf_wa", rf_wa, 8);
`else
    chk("t4_c6_stall", stall_pipe, 0);
    chk("t4_c6_rf_wa", rf_wa, 1);
    chk("t4_c6_rf_wd", rf_wd, 32'hA1);
    chk("t4_c6_full", m_ready, 0);
    drv(1, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    chk("t4_c7_rf_wa", rf_wa, 7);
    chk("t4_c7_full", m_ready, 0);
    drv(1, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    chk("t4_c8_rf_wa", rf_wa, 8);
    chk("t4_c8_m_ready", m_ready, 1);
`endif
    drv(1, 0, 0, 0, 0, 0, 0, 1, 9);
    chk("t5_x9_wr", rf_wr, 1);
    chk("t5_x9_wa", rf_wa, 9);
    chk("t5_x9_wd", rf_wd, 32'h99);
    drv(1, 0, 0, 0, 1, 0, 32'h55, 0, 0);
    chk("t5_set_wins", pend_mask, 32'h200);
    chk("t5_x0_push_ready", m_ready, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_x0_rf_wr", rf_wr, 0);
    drv(1, 0, 0, 0, 1, 9, 32'h9, 0, 0);
    chk("t5_x0_popped", rf_wr, 0);
    chk("t5_iss_x0", pend_mask, 32'h200);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("t6_x9_wa", rf_wa, 9);
    chk("t6_x9_wr", rf_wr, 1);
    drv(1, 1, 1, 32'hA1, 1, 5, 32'h5, 1, 7);
    chk("t6_p_wa", rf_wa, 1);
    chk("t6_pend5", pend_mask, 32'h20);
    drv(1, 1, 1, 32'hA1, 1, 7, 32'h7, 0, 0);
    chk("t6_push2_ready", m_ready, 1);
    drv(1, 1, 1, 32'hA1, 0, 0, 0, 0, 0);
    chk("t6_pend_a0", pend_mask, 32'hA0);
    chk("t6_full", m_ready, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_m_ready", m_ready, 0);
    chk("t6_rst_rf_wr", rf_wr, 0);
    chk("t6_rst_stall", stall_pipe, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_pend_clr", pend_mask, 0);
    chk("t6_fifo_empty", rf_wr, 0);
    chk("t6_m_ready", m_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
